seq_alu: RTL

Parametrised, registered successor to the datapath ALU, feeding the Accumulator. It adds a `WIDTH` parameter, shift/rotate ops and an iterative shift-add multiplier, plus a start/busy/done handshake and registered carry and zero flags. Single-cycle ops complete one cycle after acceptance. MUL takes `WIDTH` cycles, during which the instruction decoder stalls on `busy`.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between a requester and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] accu_in;
  logic [WIDTH-1:0] data_in;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             zf;

  modport master (
    output start, op, accu_in, data_in, ci,
    input  busy, done, result, co, zf
  );

  modport slave (
    input  start, op, accu_in, data_in, ci,
    output busy, done, result, co, zf
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with shifts/rotates and an optional iterative shift-add MUL.
// Define SEQ_ALU_MUL_EN to compile in the multiplier (op 12) and its MUL state.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;

  // Returns {co, result} for every op that completes in one cycle.
  function automatic logic [WIDTH:0] alu_single(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             ci
  );
    logic [SHW-1:0]     n;
    logic [WIDTH:0]     sh;
    logic [2*WIDTH-1:0] rot;
    int                 r;
    n   = b[SHW-1:0];
    r   = int'(n) % WIDTH;
    sh  = '0;
    rot = '0;
    alu_single = '0;
    case (op)
      OP_ADD: alu_single = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      OP_SUB: alu_single = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
      OP_AND: alu_single = {1'b0, a & b};
      OP_OR:  alu_single = {1'b0, a | b};
      OP_XOR: alu_single = {1'b0, a ^ b};
      OP_NOT: alu_single = {1'b0, ~a};
      OP_LD:  alu_single = {1'b0, b};
      OP_SHL: alu_single = {1'b0, a} << n;
      OP_SHR: begin
        sh = {a, 1'b0} >> n;
        alu_single = {sh[0], sh[WIDTH:1]};
      end
      OP_ROL: begin
        rot = {a, a} << r;
        alu_single = {1'b0, rot[2*WIDTH-1:WIDTH]};
      end
      OP_ROR: begin
        rot = {a, a} >> r;
        alu_single = {1'b0, rot[WIDTH-1:0]};
      end
      default: alu_single = '0;
    endcase
  endfunction

  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             zf_q;
  logic             busy;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'd12;
  localparam logic [0:0]     S_IDLE   = 1'b0;
  localparam logic [0:0]     S_MUL    = 1'b1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_nxt;

  assign busy     = (state_q == S_MUL);
  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    co_d     = co_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.accu_in};
            mplier_d = bus.data_in;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            {co_d, result_d} = alu_single(bus.op, bus.accu_in, bus.data_in, bus.ci);
            done_d = 1'b1;
          end
        end
      end
      default: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final partial product is folded straight into the result.
        if (cnt_q == CNT_LAST) begin
          result_d = prod_nxt[WIDTH-1:0];
          co_d     = |prod_nxt[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end
`else
  assign busy = 1'b0;

  always_comb begin
    result_d = result_q;
    co_d     = co_q;
    done_d   = 1'b0;
    if (bus.start) begin
      {co_d, result_d} = alu_single(bus.op, bus.accu_in, bus.data_in, bus.ci);
      done_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      zf_q     <= 1'b1;
    end else begin
      done_q   <= done_d;
      result_q <= result_d;
      co_q     <= co_d;
      zf_q     <= (result_d == '0);
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.zf     = zf_q;

endmodule
